// File: rtl/register_commit_pkg.sv
// Shared types for the register commit slice: memory-op encoding, register index, FSM state.
package types;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } rv32_memop;

  typedef logic [4:0] rv32_register;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rc_state;

  function automatic logic is_store(input rv32_memop op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/register_commit_load_align.sv
// Combinational load alignment: byte/halfword selection with sign or zero extension.
module load_align
  import types::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  rv32_memop   memop,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[{offset, 3'b000} +: 8];
    half_sel = data[{offset[1], 4'b0000} +: 16];
    unique case (memop)
      MEM_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: result = {24'h000000, byte_sel};
      MEM_LH:  result = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: result = {16'h0000, half_sel};
      default: result = data;
    endcase
  end

endmodule

// File: rtl/register_commit.sv
// Architectural register file with write-back commit, post-reset clear sequence and commit counter.
// Optional same-cycle read bypass of the committing value: define REGFILE_BYPASS_EN.
module register_commit
  import types::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [31:0]  i_data,
  input  logic [1:0]   i_offset,
  input  rv32_memop    i_memop,
  input  rv32_register i_rd,
  input  rv32_register i_rs1,
  input  rv32_register i_rs2,
  output logic [31:0]  o_rs1_data,
  output logic [31:0]  o_rs2_data,
  output logic         o_busy,
  output logic [31:0]  o_commit_count
);

  localparam rv32_register LAST_IDX = rv32_register'(NUM_REGS - 1);

  logic [31:0]  regs [NUM_REGS];
  rc_state      state;
  rv32_register clear_idx;
  logic [31:0]  commit_count;
  logic [31:0]  aligned;
  logic         commit;
  logic [31:0]  rs1_stored;
  logic [31:0]  rs2_stored;

  load_align u_load_align (
    .data   (i_data),
    .offset (i_offset),
    .memop  (i_memop),
    .result (aligned)
  );

  assign commit = i_valid && (state == RUN) && (i_rd != '0)
                  && (32'(i_rd) < NUM_REGS) && !is_store(i_memop);

  // Register 0 is never written; the read path supplies its zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= CLEAR;
      clear_idx    <= rv32_register'(1);
      commit_count <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          regs[clear_idx] <= '0;
          if (clear_idx == LAST_IDX) begin
            state <= RUN;
          end else begin
            clear_idx <= clear_idx + rv32_register'(1);
          end
        end
        RUN: begin
          if (commit) begin
            regs[i_rd]   <= aligned;
            commit_count <= commit_count + 32'd1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_comb begin
    rs1_stored = '0;
    rs2_stored = '0;
    if ((i_rs1 != '0) && (32'(i_rs1) < NUM_REGS)) rs1_stored = regs[i_rs1];
    if ((i_rs2 != '0) && (32'(i_rs2) < NUM_REGS)) rs2_stored = regs[i_rs2];
  end

`ifdef REGFILE_BYPASS_EN
  // commit already excludes rd==0, so x0 can never be forwarded.
  assign o_rs1_data = (commit && (i_rs1 == i_rd)) ? aligned : rs1_stored;
  assign o_rs2_data = (commit && (i_rs2 == i_rd)) ? aligned : rs2_stored;
`else
  assign o_rs1_data = rs1_stored;
  assign o_rs2_data = rs2_stored;
`endif

  assign o_busy         = (state == CLEAR);
  assign o_commit_count = commit_count;

endmodule

// File: tb/tb_register_commit.sv
// Directed bench for register_commit: clear sequence, load alignment, discards, bypass, resets, counter wrap.
module tb_register_commit;
  import types::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic [31:0]  data = '0;
  logic [1:0]   offset = '0;
  rv32_memop    memop = MEM_NONE;
  rv32_register rd = '0;
  rv32_register rs1 = '0;
  rv32_register rs2 = '0;
  logic [31:0]  rs1_data;
  logic [31:0]  rs2_data;
  logic         busy;
  logic [31:0]  commit_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_busy;

  register_commit #(.NUM_REGS(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_valid        (valid),
    .i_data         (data),
    .i_offset       (offset),
    .i_memop        (memop),
    .i_rd           (rd),
    .i_rs1          (rs1),
    .i_rs2          (rs2),
    .o_rs1_data     (rs1_data),
    .o_rs2_data     (rs2_data),
    .o_busy         (busy),
    .o_commit_count (commit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd_check(input rv32_register r, input logic [31:0] exp, input string tag);
    rs1 = r;
    rs2 = r;
    #1;
    check({tag, "/rs1"}, rs1_data, exp);
    check({tag, "/rs2"}, rs2_data, exp);
  endtask

  task automatic do_commit(input rv32_memop op, input rv32_register r,
                           input logic [31:0] d, input logic [1:0] off);
    @(negedge clk);
    valid = 1'b1; memop = op; rd = r; data = d; offset = off;
    @(posedge clk);
    #1;
    valid = 1'b0; memop = MEM_NONE; rd = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid = 1'b0;
  endtask

  // Counts negedges with busy high; ends on a negedge with busy low (or at the bound).
  task automatic count_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    // Power-on reset: one cycle with rst high.
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("busy_after_reset", 32'(busy), 32'd1);
    check("count_after_reset", commit_count, 32'd0);
    count_busy(n_busy);
    check("clear_cycles_initial", 32'(n_busy), 32'd31);
    check("busy_low_after_clear", 32'(busy), 32'd0);
    for (int i = 0; i < 32; i++) rd_check(rv32_register'(i), 32'd0, $sformatf("x%0d_cleared", i));
    check("count_after_clear", commit_count, 32'd0);

    // Load alignment.
    do_commit(MEM_LB, 5'd5, 32'h80FF1234, 2'd3);
    rd_check(5'd5, 32'hFFFFFF80, "lb_off3");
    check("count_1", commit_count, 32'd1);
    do_commit(MEM_LBU, 5'd5, 32'h80FF1234, 2'd3);
    rd_check(5'd5, 32'h00000080, "lbu_off3");
    do_commit(MEM_LHU, 5'd5, 32'h80FF1234, 2'd2);
    rd_check(5'd5, 32'h000080FF, "lhu_off2");
    do_commit(MEM_LH, 5'd6, 32'h80FF1234, 2'd3);
    rd_check(5'd6, 32'hFFFF80FF, "lh_off3_bit0_ignored");
    do_commit(MEM_LB, 5'd6, 32'h80FF1234, 2'd0);
    rd_check(5'd6, 32'h00000034, "lb_off0_positive");
    do_commit(MEM_LW, 5'd8, 32'h80FF1234, 2'd1);
    rd_check(5'd8, 32'h80FF1234, "lw_unchanged");
    do_commit(MEM_NONE, 5'd7, 32'h11111111, 2'd0);
    rd_check(5'd7, 32'h11111111, "none_unchanged");
    check("count_7", commit_count, 32'd7);

    // Discarded commits.
    do_commit(MEM_LW, 5'd0, 32'hDEADBEEF, 2'd0);
    rd_check(5'd0, 32'd0, "x0_write_ignored");
    check("count_after_x0", commit_count, 32'd7);
    do_commit(MEM_SW, 5'd7, 32'hCAFEF00D, 2'd0);
    rd_check(5'd7, 32'h11111111, "sw_no_write");
    check("count_after_sw", commit_count, 32'd7);
    do_commit(MEM_SB, 5'd8, 32'hCAFEF00D, 2'd0);
    rd_check(5'd8, 32'h80FF1234, "sb_no_write");
    check("count_after_sb", commit_count, 32'd7);

    // Same-cycle read of the committing register.
    do_commit(MEM_NONE, 5'd3, 32'hAAAA0000, 2'd0);
    @(negedge clk);
    valid = 1'b1; memop = MEM_NONE; rd = 5'd3; data = 32'h12345678; rs1 = 5'd3; rs2 = 5'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_rs1", rs1_data, 32'h12345678);
`else
    check("no_bypass_rs1", rs1_data, 32'hAAAA0000);
`endif
    check("bypass_other_reg", rs2_data, 32'd0);
    @(posedge clk);
    #1;
    valid = 1'b0; rd = '0;
    rd_check(5'd3, 32'h12345678, "x3_after_commit");
    check("count_9", commit_count, 32'd9);

    @(negedge clk);
    valid = 1'b1; memop = MEM_LW; rd = 5'd0; data = 32'hFFFFFFFF; rs1 = 5'd0;
    #1;
    check("x0_never_bypassed", rs1_data, 32'd0);
    @(posedge clk);
    #1;
    valid = 1'b0;
    check("count_after_x0_bypass", commit_count, 32'd9);

    // Counter wrap through a direct preload of the internal counter.
    @(negedge clk);
    dut.commit_count = 32'hFFFFFFFF;
    #1;
    check("count_preloaded", commit_count, 32'hFFFFFFFF);
    do_commit(MEM_NONE, 5'd10, 32'h00000005, 2'd0);
    check("count_wrap", commit_count, 32'd0);
    rd_check(5'd10, 32'h00000005, "x10_at_wrap");
    do_commit(MEM_NONE, 5'd11, 32'h00000006, 2'd0);
    check("count_after_wrap", commit_count, 32'd1);

    // Reset in RUN, with a commit on the reset edge.
    do_commit(MEM_NONE, 5'd9, 32'h00000055, 2'd0);
    rd_check(5'd9, 32'h00000055, "x9_written");
    @(negedge clk);
    rst = 1'b1; valid = 1'b1; memop = MEM_NONE; rd = 5'd9; data = 32'h00000077;
    @(posedge clk);
    #1;
    rst = 1'b0; valid = 1'b0; rd = '0;
    check("busy_after_run_reset", 32'(busy), 32'd1);
    check("count_after_run_reset", commit_count, 32'd0);
    count_busy(n_busy);
    check("clear_cycles_run_reset", 32'(n_busy), 32'd31);
    rd_check(5'd9, 32'd0, "x9_cleared");
    rd_check(5'd10, 32'd0, "x10_cleared");
    check("count_reset_edge_commit_dropped", commit_count, 32'd0);

    // Reset mid-CLEAR, with commits presented while busy.
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      valid = 1'b1; memop = MEM_LW; rd = 5'd12; data = 32'h00000099;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; valid = 1'b0; rd = '0;
    check("busy_after_clear_reset", 32'(busy), 32'd1);
    count_busy(n_busy);
    check("clear_cycles_mid_clear", 32'(n_busy), 32'd31);
    check("count_busy_commits_dropped", commit_count, 32'd0);
    rd_check(5'd12, 32'd0, "x12_busy_drop");
    rd_check(5'd31, 32'd0, "x31_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
